lc3_ctrl_fsm: RTL
=================

Name: lc3_ctrl_fsm

Overview:
Parametrised LC-3 instruction sequencer/decoder and successor to the Lab 6 control unit. It drives all datapath load, gate, mux and memory-enable signals. Unrolled per-cycle memory states are replaced by one counted wait state, sized by MEM_WAIT, which serves fetch, load, indirect and store accesses. It adds LD/ST/LDI/STI/LEA/JSRR and configurable PAUSE and illegal-opcode handling. It sits between IR/NZP/BEN logic and the datapath in the slc3 top level.

Parameters:
MEM_WAIT, 2, SRAM access length in cycles (>=1); Mem_OE or Mem_WE is held low for exactly this many cycles per access.
PAUSE_EN, 1, 1: opcode 1101 enters PAUSE handshake; 0: opcode 1101 is a NOP (returns to FETCH).
ILLEGAL_HALT, 0, 1: opcodes 1000/1111 go to HALTED; 0: they are NOPs.

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high; forces HALTED
Run  in  1  start request, sampled only in HALTED
Continue  in  1  PAUSE handshake level
Opcode  in  4  IR[15:12]
IR_5  in  1  immediate select for ADD/AND
IR_11  in  1  JSR(1)/JSRR(0)
BEN  in  1  branch-enable flop value
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle
MIO_EN  out  1  MDR source: 1=memory, 0=bus
PCMUX  out  2  00=PC+1, 01=bus, 10=address adder
DRMUX  out  1  0=IR[11:9], 1=R7
SR1MUX  out  1  0=IR[11:9], 1=IR[8:6]
SR2MUX  out  1  0=register, 1=SEXT imm5
ADDR1MUX  out  1  0=PC, 1=SR1
ADDR2MUX  out  2  00=0, 01=off6, 10=off9, 11=off11
ALUK  out  2  00=ADD, 01=AND, 10=NOT, 11=PASSA
Mem_OE, Mem_WE  out  1 each  active-low SRAM enables
Busy  out  1  high whenever state != HALTED

Behaviour:
- Moore outputs decoded from state only (plus IR_5/IR_11 pass-through). Default every load/gate = 0, mux = 0, Mem_OE = Mem_WE = 1, MIO_EN = 0.
- Reset (asynchronous): state=HALTED, wait counter=0. All outputs go to their defaults immediately, including mid-access; a pending write is aborted.
- Wait counter: width clog2(MEM_WAIT+1). Cleared on entry to any MEM state. The MEM state exits when the count reaches MEM_WAIT-1.
- Read access (MEM_RD): Mem_OE=0 and MIO_EN=1 throughout. LD_MDR=1 only on the final cycle.
- Write access (MEM_WR): Mem_WE=0 throughout. Mem_OE=1.
- HALTED -> FETCH when Run=1; otherwise stay.
- FETCH: GatePC, LD_MAR, LD_PC, PCMUX=00.
- Then MEM_RD(fetch) -> LOAD_IR (GateMDR, LD_IR) -> DECODE (LD_BEN).
- DECODE dispatch:
  - ADD(0001), AND(0101), NOT(1001): one cycle. GateALU, LD_REG, LD_CC, SR1MUX=1, SR2MUX=IR_5, ALUK=00/01/10. Then FETCH.
  - BR(0000): if BEN, PC_BR (LD_PC, PCMUX=10, ADDR2MUX=10) -> FETCH; else straight to FETCH.
  - JMP(1100): LD_PC, PCMUX=10, SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00 -> FETCH.
  - JSR(0100): SAVE_R7 (GatePC, LD_REG, DRMUX=1), then JSR_PC. JSR_PC: LD_PC, PCMUX=10; IR_11=1 -> ADDR1MUX=0, ADDR2MUX=11; IR_11=0 -> SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00.
    - Limitation: JSRR with BaseR=R7 jumps to the old PC.
  - LD(0010)/LDI(1010)/ST(0011)/STI(1011): ADDR_PC9 (GateMARMUX, LD_MAR, ADDR1MUX=0, ADDR2MUX=10).
  - LDR(0110)/STR(0111): ADDR_R6 (GateMARMUX, LD_MAR, SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01).
  - LEA(1110): GateMARMUX, LD_REG, ADDR2MUX=10; CC unchanged.
- Memory sequences:
  - Loads: MEM_RD -> WB (GateMDR, LD_REG, LD_CC).
  - LDI: MEM_RD -> IND_MAR (GateMDR, LD_MAR) -> MEM_RD -> WB.
  - Stores: ST_MDR (ALUK=11, SR1MUX=0, GateALU, LD_MDR, MIO_EN=0) -> MEM_WR -> FETCH.
  - STI: MEM_RD -> IND_MAR -> ST_MDR -> MEM_WR.
  - A return-target register selects the post-MEM state. It is written in the state that enters MEM and reset to FETCH.
- PAUSE(1101), PAUSE_EN=1: PAUSE1 (LD_LED) waits for Continue=1 -> PAUSE2 (LD_LED) waits for Continue=0 -> FETCH.
- Illegal opcodes 1000/1111: HALTED if ILLEGAL_HALT, else FETCH.
- Run is ignored outside HALTED.

Test Plan:
- MEM_WAIT=2, Run pulse, IR=0x1261 (ADD R1,R1,#1): Busy rises; Mem_OE low exactly 2 cycles and LD_MDR on the 2nd; ADD state has SR2MUX=1, LD_CC=1; FETCH reached 7 cycles after leaving HALTED.
- MEM_WAIT=4, IR=0xA402 (LDI): two read accesses of 4 cycles each with IND_MAR between them; WB asserts LD_REG+LD_CC.
- IR=0x0402 with BEN=1 then BEN=0: PC_BR is entered once (LD_PC, PCMUX=10, ADDR2MUX=10); with BEN=0 DECODE goes directly to FETCH.
- IR=0x4802 (JSR) vs 0x4080 (JSRR R2): SAVE_R7 then JSR_PC with ADDR2MUX=11/ADDR1MUX=0 vs ADDR1MUX=1/ADDR2MUX=00.
- PAUSE_EN=1, IR=0xD0FF: LD_LED held, stays in PAUSE1 until Continue=1 and in PAUSE2 until Continue=0. With PAUSE_EN=0 the same IR returns to FETCH with LD_LED never high.
- Reset asserted during cycle 2 of an STI write (MEM_WAIT=3): Mem_WE returns to 1 asynchronously, Busy=0. After release, Run=0 holds HALTED.

Source files
------------

// File: rtl/lc3_ctrl_fsm_if.sv
// Control/status bundle between the LC-3 sequencer and the slc3 datapath.
interface lc3_ctrl_fsm_if;
    logic       Run, Continue;
    logic [3:0] Opcode;
    logic       IR_5, IR_11, BEN;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       MIO_EN;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX, ALUK;
    logic       Mem_OE, Mem_WE, Busy;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN, PCMUX,
        output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_OE, Mem_WE, Busy
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN, PCMUX,
        input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_OE, Mem_WE, Busy
    );
endinterface

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 instruction sequencer: Moore FSM with one counted SRAM wait state
// shared by fetch, load, indirect and store accesses.
module lc3_ctrl_fsm #(
    parameter int MEM_WAIT     = 2,
    parameter bit PAUSE_EN     = 1'b1,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic           Clk,
    input  logic           Reset,
    lc3_ctrl_fsm_if.master bus
);
    localparam int CW = $clog2(MEM_WAIT + 1);

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH, S_MEM_RD, S_MEM_WR, S_LOAD_IR, S_DECODE,
        S_ADD, S_AND, S_NOT, S_PC_BR, S_JMP, S_SAVE_R7, S_JSR_PC,
        S_ADDR_PC9, S_ADDR_R6, S_LEA, S_WB, S_IND_MAR, S_ST_MDR,
        S_PAUSE1, S_PAUSE2
    } state_e;

    state_e        state_q, state_d;
    state_e        ret_q, ret_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_last;

    assign mem_last = (cnt_q == CW'(MEM_WAIT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_HALTED;
            ret_q   <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any state that enters a MEM state also records where the access returns to.
    always_comb begin
        // NOTE: every target gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = '0;
        unique case (state_q)
            S_HALTED:  if (bus.Run) state_d = S_FETCH;
            S_FETCH:   begin state_d = S_MEM_RD; ret_d = S_LOAD_IR; end
            S_MEM_RD, S_MEM_WR: begin
                if (mem_last) state_d = ret_q;
                else          cnt_d   = cnt_q + 1'b1;
            end
            S_LOAD_IR: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b0000: state_d = bus.BEN ? S_PC_BR : S_FETCH;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_SAVE_R7;
                    4'b0010, 4'b0011, 4'b1010, 4'b1011: state_d = S_ADDR_PC9;
                    4'b0110, 4'b0111: state_d = S_ADDR_R6;
                    4'b1110: state_d = S_LEA;
                    4'b1101: state_d = PAUSE_EN ? S_PAUSE1 : S_FETCH;
                    default: state_d = ILLEGAL_HALT ? S_HALTED : S_FETCH;
                endcase
            end
            S_ADDR_PC9, S_ADDR_R6: begin
                case (bus.Opcode)
                    4'b0011, 4'b0111: state_d = S_ST_MDR;
                    4'b1010, 4'b1011: begin state_d = S_MEM_RD; ret_d = S_IND_MAR; end
                    default:          begin state_d = S_MEM_RD; ret_d = S_WB; end
                endcase
            end
            S_IND_MAR: begin
                if (bus.Opcode[0]) state_d = S_ST_MDR;
                else begin state_d = S_MEM_RD; ret_d = S_WB; end
            end
            S_ST_MDR:  begin state_d = S_MEM_WR; ret_d = S_FETCH; end
            S_SAVE_R7: state_d = S_JSR_PC;
            S_PAUSE1:  if (bus.Continue)  state_d = S_PAUSE2;
            S_PAUSE2:  if (!bus.Continue) state_d = S_FETCH;
            S_ADD, S_AND, S_NOT, S_PC_BR, S_JMP, S_JSR_PC, S_LEA, S_WB:
                       state_d = S_FETCH;
            default:   state_d = S_HALTED;
        endcase
    end

    always_comb begin
        bus.LD_MAR = 1'b0;  bus.LD_MDR = 1'b0;  bus.LD_IR  = 1'b0;  bus.LD_BEN = 1'b0;
        bus.LD_CC  = 1'b0;  bus.LD_REG = 1'b0;  bus.LD_PC  = 1'b0;  bus.LD_LED = 1'b0;
        bus.GatePC = 1'b0;  bus.GateMDR = 1'b0; bus.GateALU = 1'b0; bus.GateMARMUX = 1'b0;
        bus.MIO_EN = 1'b0;  bus.PCMUX  = 2'b00; bus.DRMUX  = 1'b0;  bus.SR1MUX = 1'b0;
        bus.SR2MUX = 1'b0;  bus.ADDR1MUX = 1'b0; bus.ADDR2MUX = 2'b00; bus.ALUK = 2'b00;
        bus.Mem_OE = 1'b1;  bus.Mem_WE = 1'b1;
        bus.Busy   = (state_q != S_HALTED);
        case (state_q)
            S_FETCH:   begin bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.LD_PC = 1'b1; end
            S_MEM_RD:  begin bus.Mem_OE = 1'b0; bus.MIO_EN = 1'b1; bus.LD_MDR = mem_last; end
            S_MEM_WR:  bus.Mem_WE = 1'b0;
            S_LOAD_IR: begin bus.GateMDR = 1'b1; bus.LD_IR = 1'b1; end
            S_DECODE:  bus.LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                bus.GateALU = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
                bus.SR1MUX  = 1'b1; bus.SR2MUX = bus.IR_5;
                bus.ALUK    = (state_q == S_ADD) ? 2'b00 : (state_q == S_AND) ? 2'b01 : 2'b10;
            end
            S_PC_BR:   begin bus.LD_PC = 1'b1; bus.PCMUX = 2'b10; bus.ADDR2MUX = 2'b10; end
            S_JMP: begin
                bus.LD_PC = 1'b1; bus.PCMUX = 2'b10; bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b1;
            end
            S_SAVE_R7: begin bus.GatePC = 1'b1; bus.LD_REG = 1'b1; bus.DRMUX = 1'b1; end
            S_JSR_PC: begin
                bus.LD_PC = 1'b1; bus.PCMUX = 2'b10;
                if (bus.IR_11) bus.ADDR2MUX = 2'b11;
                else begin bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b1; end
            end
            S_ADDR_PC9: begin bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1; bus.ADDR2MUX = 2'b10; end
            S_ADDR_R6: begin
                bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1;
                bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = 2'b01;
            end
            S_LEA:     begin bus.GateMARMUX = 1'b1; bus.LD_REG = 1'b1; bus.ADDR2MUX = 2'b10; end
            S_WB:      begin bus.GateMDR = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1; end
            S_IND_MAR: begin bus.GateMDR = 1'b1; bus.LD_MAR = 1'b1; end
            S_ST_MDR:  begin bus.GateALU = 1'b1; bus.LD_MDR = 1'b1; bus.ALUK = 2'b11; end
            S_PAUSE1, S_PAUSE2: bus.LD_LED = 1'b1;
            default: ;
        endcase
    end
endmodule
